// File: rtl/stim_sweep_pkg.sv
// Shared types for the value-sweep sequencer: sweep modes and FSM states.
package stim_sweep_pkg;

   typedef enum logic [1:0] {
      MODE_FULL  = 2'd0,
      MODE_RANGE = 2'd1,
      MODE_LOOP  = 2'd2,
      MODE_RSVD  = 2'd3
   } sweep_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EMIT  = 2'd1,
      ST_DWELL = 2'd2,
      ST_DONE  = 2'd3
   } sweep_state_e;

endpackage

// File: rtl/sweep_dwell_timer.sv
// Down-counter for the idle gap between sweep values; expire_o marks the last dwell cycle.
module sweep_dwell_timer #(
   parameter int DWELL_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic [DWELL_W-1:0] load_val_i,
   output logic               expire_o
);

   logic [DWELL_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - DWELL_W'(1);
      end
   end

   // A load of N keeps the consumer idle for exactly N cycles.
   assign expire_o = (cnt_q == DWELL_W'(1));

endmodule

// File: rtl/stim_sweep_gen.sv
// Clocked value-sweep sequencer: full-range or start..stop..step values on a valid/ready stream.
module stim_sweep_gen
   import stim_sweep_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int DWELL_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic               abort_i,
   input  logic [1:0]         cfg_mode_i,
   input  logic [DATA_W-1:0]  cfg_start_i,
   input  logic [DATA_W-1:0]  cfg_stop_i,
   input  logic [DATA_W-1:0]  cfg_step_i,
   input  logic [DWELL_W-1:0] cfg_dwell_i,
   output logic [DATA_W-1:0]  val_o,
   output logic               valid_o,
   input  logic               ready_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [DATA_W:0]    count_o
);

   sweep_state_e       state_q;
   sweep_mode_e        mode_q;
   logic [DATA_W-1:0]  start_q, stop_q, step_q, val_q;
   logic [DWELL_W-1:0] dwell_q;
   logic [DATA_W:0]    count_q;
   logic               valid_q, busy_q, done_q;

   sweep_mode_e       cfg_mode;
   logic [DATA_W-1:0] start_d, stop_d, step_d;
   logic [DATA_W:0]   next_val;
   logic              last_val, hs, to_dwell, dwell_expire;

   assign cfg_mode = sweep_mode_e'(cfg_mode_i);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      start_d = cfg_start_i;
      stop_d  = cfg_stop_i;
      step_d  = (cfg_step_i == '0) ? DATA_W'(1) : cfg_step_i;
      if (cfg_mode == MODE_FULL) begin
         start_d = '0;
         stop_d  = '1;
         step_d  = DATA_W'(1);
      end
   end

   // One extra bit so a step past 2^DATA_W-1 shows up as a carry instead of wrapping.
   assign next_val = {1'b0, val_q} + {1'b0, step_q};
   assign last_val = next_val[DATA_W] || (next_val[DATA_W-1:0] > stop_q);
   assign hs       = valid_q && ready_i;
   assign to_dwell = (state_q == ST_EMIT) && hs && !abort_i && (dwell_q != '0)
                     && (!last_val || mode_q == MODE_LOOP);

   sweep_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (to_dwell),
      .load_val_i (dwell_q),
      .expire_o   (dwell_expire)
   );

   // NOTE: non-blocking assignments so every register here samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_FULL;
         start_q <= '0;
         stop_q  <= '0;
         step_q  <= '0;
         dwell_q <= '0;
         val_q   <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (hs) count_q <= count_q + (DATA_W+1)'(1);
         if (abort_i) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: if (start_i) begin
                  mode_q  <= cfg_mode;
                  start_q <= start_d;
                  stop_q  <= stop_d;
                  step_q  <= step_d;
                  dwell_q <= cfg_dwell_i;
                  count_q <= '0;
                  if (start_d > stop_d) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_EMIT;
                     val_q   <= start_d;
                     valid_q <= 1'b1;
                     busy_q  <= 1'b1;
                  end
               end
               ST_EMIT: if (hs) begin
                  if (last_val && mode_q != MODE_LOOP) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                     valid_q <= 1'b0;
                     busy_q  <= 1'b0;
                  end else begin
                     val_q <= last_val ? start_q : next_val[DATA_W-1:0];
                     if (dwell_q != '0) begin
                        state_q <= ST_DWELL;
                        valid_q <= 1'b0;
                     end
                  end
               end
               ST_DWELL: if (dwell_expire) begin
                  state_q <= ST_EMIT;
                  valid_q <= 1'b1;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign val_o   = val_q;
   assign valid_o = valid_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;
   assign count_o = count_q;

endmodule
